// File: rtl/score_disp_ctrl.sv
// score_disp_ctrl
// Converts the 8-bit game score into three BCD digits with a sequential
// shift-add-3 engine and drives the seven-segment driver's digit and blank
// inputs. Leading zeros are blanked, and the whole display blinks while the
// game is in the dead state.
//
// Ports
//   clk    in   1   system clock, rising edge
//   RST    in   1   synchronous active-high reset
//   score  in   8   binary score, sampled only while idle
//   dead   in   1   game-over level, enables the blink overlay
//   hexs   out  16  {4'h0, hundreds, tens, units}
//   les    out  4   digit blank mask, bit i = 1 blanks digit i
//   busy   out  1   conversion in progress
//   done   out  1   one-cycle pulse after new hexs/les are committed
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for score to differ from the last converted value
// SHIFT  | one adjust-and-shift iteration per clock, 8 iterations
// COMMIT | latch BCD result and blank mask, pulse done next cycle
module score_disp_ctrl #(
   parameter int BLINK_DIV = 25
) (
   input  logic        clk,
   input  logic        RST,
   input  logic [7:0]  score,
   input  logic        dead,
   output logic [15:0] hexs,
   output logic [3:0]  les,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } state_t;

   localparam logic [BLINK_DIV-1:0] BLINK_ONE = 1;

   state_t                state, state_nxt;
   logic [7:0]            shadow;
   logic [19:0]           sreg;
   logic [19:0]           sreg_adj;
   logic [19:0]           sreg_shifted;
   logic [2:0]            bitcnt;
   logic [11:0]           hexs_r;
   logic [3:0]            les_r;
   logic                  done_r;
   logic [BLINK_DIV-1:0]  blink_cnt;
   logic                  score_changed;

   assign score_changed = (score != shadow);

   // Add 3 to every BCD nibble that is 5 or more before the shift, so the
   // doubling carries correctly into the next decimal digit.
   always_comb begin
      sreg_adj = sreg;
      if (sreg[11:8] >= 4'd5)
         sreg_adj[11:8] = sreg[11:8] + 4'd3;
      if (sreg[15:12] >= 4'd5)
         sreg_adj[15:12] = sreg[15:12] + 4'd3;
      if (sreg[19:16] >= 4'd5)
         sreg_adj[19:16] = sreg[19:16] + 4'd3;
      sreg_shifted = sreg_adj << 1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (score_changed)
               state_nxt = SHIFT;
         end
         SHIFT: begin
            if (bitcnt == 3'd7)
               state_nxt = COMMIT;
         end
         COMMIT: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state  <= IDLE;
         shadow <= 8'h00;
         sreg   <= 20'h00000;
         bitcnt <= 3'd0;
         hexs_r <= 12'h000;
         les_r  <= 4'b1110;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= 1'b0;
         case (state)
            IDLE: begin
               if (score_changed) begin
                  shadow <= score;
                  sreg   <= {12'h000, score};
                  bitcnt <= 3'd0;
               end
            end
            SHIFT: begin
               sreg   <= sreg_shifted;
               bitcnt <= bitcnt + 3'd1;
            end
            COMMIT: begin
               hexs_r <= sreg[19:8];
               les_r  <= {1'b1,
                          (sreg[19:16] == 4'd0),
                          (sreg[19:16] == 4'd0) && (sreg[15:12] == 4'd0),
                          1'b0};
               done_r <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Held at zero outside the dead state so every blink episode opens in
   // the visible half-period.
   always_ff @(posedge clk) begin
      if (RST)
         blink_cnt <= '0;
      else if (dead)
         blink_cnt <= blink_cnt + BLINK_ONE;
      else
         blink_cnt <= '0;
   end

   // dead gates the overlay directly so releasing it restores the digits
   // in the same cycle, without waiting for the counter to clear.
   assign les  = les_r | {4{dead & blink_cnt[BLINK_DIV-1]}};
   assign hexs = {4'h0, hexs_r};
   assign busy = (state != IDLE);
   assign done = done_r;

endmodule

// File: tb/tb_score_disp_ctrl.sv
// Directed bench for score_disp_ctrl. Inputs are driven and outputs sampled
// 1 time unit after each rising edge.
module tb_score_disp_ctrl;

   logic        clk;
   logic        RST;
   logic [7:0]  score;
   logic        dead;
   logic [15:0] hexs;
   logic [3:0]  les;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;
   int done_pulses;
   int done_base;

   score_disp_ctrl #(.BLINK_DIV(2)) dut (
      .clk   (clk),
      .RST   (RST),
      .score (score),
      .dead  (dead),
      .hexs  (hexs),
      .les   (les),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1)
         done_pulses++;
   end

   task automatic check_vec(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a new score; the next edge is the sampling edge E0, the commit
   // lands on E9.
   task automatic convert(input logic [7:0] v, input logic [15:0] exp_hexs,
                          input logic [3:0] exp_les, input logic [15:0] prev_hexs);
      score = v;
      tick();
      check_vec("busy_after_e0", 32'(busy), 32'd1);
      repeat (8) tick();
      check_vec("busy_after_e8", 32'(busy), 32'd1);
      check_vec("hexs_before_commit", 32'(hexs), 32'(prev_hexs));
      check_vec("done_before_commit", 32'(done), 32'd0);
      tick();
      check_vec("hexs_commit", 32'(hexs), 32'(exp_hexs));
      check_vec("les_commit", 32'(les), 32'(exp_les));
      check_vec("done_pulse", 32'(done), 32'd1);
      check_vec("busy_after_e9", 32'(busy), 32'd0);
      tick();
      check_vec("done_clear", 32'(done), 32'd0);
   endtask

   logic [3:0] blink_exp [8];

   initial begin
      vectors     = 0;
      miscompares = 0;
      done_pulses = 0;
      RST   = 1'b1;
      score = 8'd0;
      dead  = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      check_vec("rst_hexs", 32'(hexs), 32'h0000);
      check_vec("rst_les", 32'(les), 32'b1110);
      check_vec("rst_busy", 32'(busy), 32'd0);
      check_vec("rst_done", 32'(done), 32'd0);
      tick();
      tick();
      check_vec("rst_no_conv", 32'(busy), 32'd0);

      done_base = done_pulses;
      convert(8'd255, 16'h0255, 4'b1000, 16'h0000);
      check_vec("done_count_255", 32'(done_pulses - done_base), 32'd1);
      convert(8'd7,   16'h0007, 4'b1110, 16'h0255);
      convert(8'd100, 16'h0100, 4'b1000, 16'h0007);
      convert(8'd40,  16'h0040, 4'b1100, 16'h0100);

      // Change while busy: 13 arrives on the third SHIFT cycle.
      done_base = done_pulses;
      score = 8'd12;
      tick();                      // E0
      tick();                      // E1
      tick();                      // E2
      score = 8'd13;
      repeat (6) tick();           // E3..E8
      check_vec("bb_busy_e8", 32'(busy), 32'd1);
      tick();                      // E9
      check_vec("bb_hexs_first", 32'(hexs), 32'h0012);
      check_vec("bb_les_first", 32'(les), 32'b1100);
      check_vec("bb_idle_gap", 32'(busy), 32'd0);
      tick();                      // E10 samples 13
      check_vec("bb_restart", 32'(busy), 32'd1);
      repeat (8) tick();           // E11..E18
      check_vec("bb_hexs_hold", 32'(hexs), 32'h0012);
      tick();                      // E19
      check_vec("bb_hexs_second", 32'(hexs), 32'h0013);
      tick();
      check_vec("bb_done_count", 32'(done_pulses - done_base), 32'd2);

      // Blink with a 2-bit counter.
      convert(8'd5, 16'h0005, 4'b1110, 16'h0013);
      blink_exp = '{4'b1110, 4'b1110, 4'b1111, 4'b1111,
                    4'b1110, 4'b1110, 4'b1111, 4'b1111};
      dead = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0)
            tick();
         #0;
         check_vec($sformatf("blink_%0d", i), 32'(les), 32'(blink_exp[i]));
      end
      dead = 1'b0;
      #1;
      check_vec("blink_release", 32'(les), 32'b1110);
      tick();
      check_vec("blink_after", 32'(les), 32'b1110);
      dead = 1'b1;
      #1;
      check_vec("blink_restart_on", 32'(les), 32'b1110);
      tick();
      check_vec("blink_restart_on2", 32'(les), 32'b1110);
      tick();
      check_vec("blink_restart_off", 32'(les), 32'b1111);
      dead = 1'b0;
      tick();

      // Reset during SHIFT iteration 4.
      score = 8'd99;
      tick();                      // E0
      tick();                      // E1
      tick();                      // E2
      tick();                      // E3
      RST = 1'b1;
      tick();                      // E4 reset edge
      RST = 1'b0;
      check_vec("mid_rst_busy", 32'(busy), 32'd0);
      check_vec("mid_rst_hexs", 32'(hexs), 32'h0000);
      check_vec("mid_rst_les", 32'(les), 32'b1110);
      check_vec("mid_rst_done", 32'(done), 32'd0);
      convert(8'd99, 16'h0099, 4'b1100, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/score_disp_ctrl.md
# score_disp_ctrl

Display controller between the game `StateMachine` score output and the `DispNum` seven-segment driver. It converts the 8-bit binary score into three BCD digits with a sequential shift-add-3 (double-dabble) engine. It drives `DispNum`'s `HEXs` and `LES` inputs with leading-zero blanking, and blinks the whole display while the game is in the dead state. It replaces the raw-hex score hookup with a decimal readout.

## Interface
- `BLINK_DIV`, default 25: blink counter width; each on/off half-period lasts 2^(BLINK_DIV-1) clocks. Must be ≥ 2.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `score`  input  8  binary score, sampled only while idle.
- `dead`  input  1  level; high = game over, display blinks.
- `hexs`  output  16  BCD nibbles to `DispNum.HEXs`: [15:12] = 0, [11:8] = hundreds, [7:4] = tens, [3:0] = units.
- `les`  output  4  digit blank mask to `DispNum.LES`; bit i = 1 blanks digit i.
- `busy`  output  1  high while a conversion is in progress (SHIFT or COMMIT).
- `done`  output  1  one-cycle pulse in the cycle after new `hexs`/`les` are committed.

## Operation
- Registers:
  - `shadow[7:0]`: last captured score.
  - `sreg[19:0]`: 12-bit BCD field plus 8-bit binary field.
  - `bitcnt[2:0]`.
  - `hexs_r`, `les_r`.
  - `blink_cnt[BLINK_DIV-1:0]`.
  - FSM.
- FSM states are IDLE, SHIFT and COMMIT.
- IDLE:
  - If `score != shadow`: `shadow <= score`, `sreg <= {12'h000, score}`, `bitcnt <= 0`, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per clock:
  - Each BCD nibble of `sreg[19:8]` that is ≥ 5 gets +3.
  - The whole 20-bit value is then shifted left by 1.
  - `bitcnt` increments each iteration.
  - After the 8th iteration (`bitcnt == 7`), go to COMMIT.
- COMMIT:
  - `hexs_r <= {4'h0, sreg[19:8]}`.
  - `les_r` bit 3 = 1 always.
  - `les_r` bit 2 = (hundreds == 0).
  - `les_r` bit 1 = (hundreds == 0 && tens == 0).
  - `les_r` bit 0 = 0.
  - Go to IDLE.
- `done` is a register set on the COMMIT edge and cleared on the next edge.
- `score` changes during SHIFT or COMMIT are ignored. After COMMIT, IDLE compares against `shadow` (the value that was converted), so the newest score is picked up on the next IDLE cycle.
- Blink:
  - While `dead` = 1, `blink_cnt` increments every clock and wraps modulo 2^BLINK_DIV.
  - While `dead` = 0, `blink_cnt` is held at 0.
  - `les = les_r | {4{dead & blink_cnt[BLINK_DIV-1]}}`. Each dead episode starts in the on phase.
- `hexs = hexs_r`. `busy = (state != IDLE)`.
- Score range 0–255 only; the hundreds digit never exceeds 2. No overflow handling is needed.

## Timing
- Reset values:
  - `state` = IDLE.
  - `shadow` = 0, `sreg` = 0, `bitcnt` = 0, `blink_cnt` = 0.
  - `hexs` = 16'h0000, `les` = 4'b1110 (shows "0").
  - `busy` = 0, `done` = 0.
- Reset mid-conversion aborts immediately to the reset values. The previous display is discarded.
- Latency, for a score change sampled at IDLE edge E0:
  - SHIFT iterations occur at edges E1–E8; `busy` = 1 from after E0 through E9.
  - COMMIT at E9 updates `hexs`/`les`; `done` = 1 in the cycle after E9.
  - Total: outputs change 9 edges after the sampling edge.
- Back-to-back changes: minimum one IDLE cycle between conversions. Conversion period is 10 clocks.
- Blink vs. conversion:
  - The blink overlay is combinational on registered state and is independent of the FSM.
  - A commit during the off phase stays hidden until the on phase.
- `dead` falling forces `blink_cnt` to 0 on the next edge; `les` returns to `les_r` in that same cycle, since `dead` gates the overlay combinationally.

## Test plan
- Reset: assert `RST` for 2 clocks with `score` = 0 → `hexs` = 16'h0000, `les` = 4'b1110, `busy` = 0, `done` = 0. No conversion starts, because `score == shadow`.
- Conversions (each checked 9 edges after the sampling edge):
  - `score` 0 → 255: `hexs` = 16'h0255, `les` = 4'b1000, `done` pulses once.
  - `score` 7: `hexs` = 16'h0007, `les` = 4'b1110.
  - `score` 100: `hexs` = 16'h0100, `les` = 4'b1000.
  - `score` 40: `hexs` = 16'h0040, `les` = 4'b1100.
- Change while busy: `score` = 12, then `score` = 13 on the 3rd SHIFT cycle:
  - First commit gives `hexs` = 16'h0012.
  - Exactly one IDLE cycle later a new conversion starts.
  - Second commit gives 16'h0013.
  - `done` pulses twice.
- Blink with `BLINK_DIV` = 2, `score` = 5 committed, then `dead` = 1:
  - `les` sequence is 1110, 1110, 1111, 1111, repeating.
  - Dropping `dead` restores `les` = 1110 in that same cycle.
- Reset mid-conversion: `score` = 99, assert `RST` during SHIFT iteration 4 → `busy` = 0 and `hexs` = 16'h0000 after the reset edge. After release, with `score` still 99, `hexs` = 16'h0099 and `les` = 4'b1100 follow 9 edges after the first IDLE sample.
